// File: rtl/reg_writeback_queue_if.sv
// Producer, register-file write and lookup signals of the writeback queue.
// The queue owns the slave side; the producers, register file and hazard logic use the master side.
// No logic lives here, only wiring and direction.
interface reg_writeback_queue_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
);
  logic                     mem_valid;
  logic [REG_W-1:0]         mem_reg;
  logic [DATA_W-1:0]        mem_data;
  logic                     mem_ready;
  logic                     alu_valid;
  logic [REG_W-1:0]         alu_reg;
  logic [DATA_W-1:0]        alu_data;
  logic                     alu_ready;
  logic [REG_W-1:0]         DstReg;
  logic                     WriteReg;
  logic [DATA_W-1:0]        DstData;
  logic [(1<<REG_W)-1:0]    pending;
  logic [REG_W-1:0]         fwd_reg1;
  logic                     fwd_hit1;
  logic [DATA_W-1:0]        fwd_data1;
  logic [REG_W-1:0]         fwd_reg2;
  logic                     fwd_hit2;
  logic [DATA_W-1:0]        fwd_data2;

  modport slave (
    input  mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data, fwd_reg1, fwd_reg2,
    output mem_ready, alu_ready, DstReg, WriteReg, DstData, pending,
           fwd_hit1, fwd_data1, fwd_hit2, fwd_data2
  );

  modport master (
    output mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data, fwd_reg1, fwd_reg2,
    input  mem_ready, alu_ready, DstReg, WriteReg, DstData, pending,
           fwd_hit1, fwd_data1, fwd_hit2, fwd_data2
  );
endinterface

// File: rtl/reg_writeback_queue.sv
// In-order writeback FIFO merging memory and ALU results into one register-file write per cycle.
// Latency: a result accepted at edge N is presented on WriteReg/DstReg/DstData in the following cycle.
// Backpressure: ready reflects free slots including the same-edge pop; mem takes priority over alu.
module reg_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  reg_writeback_queue_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [REG_W-1:0]  ent_reg_q  [DEPTH];
  logic [REG_W-1:0]  ent_reg_d  [DEPTH];
  logic [DATA_W-1:0] ent_data_q [DEPTH];
  logic [DATA_W-1:0] ent_data_d [DEPTH];

  logic              pop;
  logic              mem_acc;
  logic              alu_acc;
  logic [CW:0]       space;
  logic [PW-1:0]     alu_idx;
  logic [PW-1:0]     scan_idx;

  // Free slots this edge count the head pop; a valid mem result reserves one slot ahead of alu.
  always_comb begin
    pop           = (count_q != '0);
    space         = (CW+1)'(DEPTH) - {1'b0, count_q} + {{CW{1'b0}}, pop};
    bus.mem_ready = (space >= (CW+1)'(1));
    bus.alu_ready = bus.mem_valid ? (space >= (CW+1)'(2)) : (space >= (CW+1)'(1));
    mem_acc       = bus.mem_valid & bus.mem_ready;
    alu_acc       = bus.alu_valid & bus.alu_ready;
  end

  // Next pointers, occupancy and entry writes; mem lands first since it is the older result.
  always_comb begin
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    wr_ptr_d   = wr_ptr_q + PW'(mem_acc) + PW'(alu_acc);
    count_d    = count_q + CW'(mem_acc) + CW'(alu_acc) - CW'(pop);
    alu_idx    = wr_ptr_q + PW'(mem_acc);
    ent_reg_d  = ent_reg_q;
    ent_data_d = ent_data_q;
    if (mem_acc) begin
      ent_reg_d[wr_ptr_q]  = bus.mem_reg;
      ent_data_d[wr_ptr_q] = bus.mem_data;
    end
    if (alu_acc) begin
      ent_reg_d[alu_idx]  = bus.alu_reg;
      ent_data_d[alu_idx] = bus.alu_data;
    end
  end

  // Control state clears asynchronously so a reset discards everything queued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry payloads carry no reset; they are only observed while counted as occupied.
  always_ff @(posedge clk) begin
    ent_reg_q  <= ent_reg_d;
    ent_data_q <= ent_data_d;
  end

  // Head write, scoreboard and forwarding; scanning oldest to youngest lets the youngest match win.
  always_comb begin
    bus.WriteReg  = pop;
    bus.DstReg    = '0;
    bus.DstData   = '0;
    bus.pending   = '0;
    bus.fwd_hit1  = 1'b0;
    bus.fwd_data1 = '0;
    bus.fwd_hit2  = 1'b0;
    bus.fwd_data2 = '0;
    scan_idx      = '0;
    if (pop) begin
      bus.DstReg  = ent_reg_q[rd_ptr_q];
      bus.DstData = ent_data_q[rd_ptr_q];
    end
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = rd_ptr_q + PW'(k);
      if (CW'(k) < count_q) begin
        bus.pending[ent_reg_q[scan_idx]] = 1'b1;
        if (ent_reg_q[scan_idx] == bus.fwd_reg1) begin
          bus.fwd_hit1  = 1'b1;
          bus.fwd_data1 = ent_data_q[scan_idx];
        end
        if (ent_reg_q[scan_idx] == bus.fwd_reg2) begin
          bus.fwd_hit2  = 1'b1;
          bus.fwd_data2 = ent_data_q[scan_idx];
        end
      end
    end
  end
endmodule

// File: tb/tb_reg_writeback_queue.sv
// Bench for reg_writeback_queue: directed scenarios followed by random producer traffic,
// all compared each cycle against a queue-based reference model.
module tb_reg_writeback_queue;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [3:0]  r;
    logic [15:0] d;
  } ent_t;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;
  logic m_acc;
  logic a_acc;
  ent_t mq[$];

  reg_writeback_queue_if #(.DATA_W(16), .REG_W(4)) bus ();

  reg_writeback_queue #(.DEPTH(DEPTH), .DATA_W(16), .REG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic mv, input logic [3:0] mr, input logic [15:0] md,
                       input logic av, input logic [3:0] ar, input logic [15:0] ad);
    bus.mem_valid = mv;
    bus.mem_reg   = mr;
    bus.mem_data  = md;
    bus.alu_valid = av;
    bus.alu_reg   = ar;
    bus.alu_data  = ad;
  endtask

  // One cycle: compare all outputs against the model mid-cycle, then advance the model at the edge.
  task automatic step();
    int          sz;
    int          freeslots;
    logic        e_mrdy;
    logic        e_ardy;
    logic [15:0] e_pend;
    logic        e_h1, e_h2;
    logic [15:0] e_d1, e_d2;
    ent_t        e;
    @(negedge clk);
    sz        = mq.size();
    freeslots = DEPTH - sz + ((sz > 0) ? 1 : 0);
    e_mrdy    = (freeslots >= 1);
    e_ardy    = (freeslots >= (bus.mem_valid ? 2 : 1));
    e_pend    = '0;
    e_h1 = 1'b0; e_d1 = '0; e_h2 = 1'b0; e_d2 = '0;
    foreach (mq[i]) begin
      e_pend = e_pend | (16'd1 << mq[i].r);
      if (mq[i].r == bus.fwd_reg1) begin e_h1 = 1'b1; e_d1 = mq[i].d; end
      if (mq[i].r == bus.fwd_reg2) begin e_h2 = 1'b1; e_d2 = mq[i].d; end
    end
    chk("write_en",  32'(bus.WriteReg),  32'(sz > 0));
    chk("dst_reg",   32'(bus.DstReg),    (sz > 0) ? 32'(mq[0].r) : 32'd0);
    chk("dst_data",  32'(bus.DstData),   (sz > 0) ? 32'(mq[0].d) : 32'd0);
    chk("pending",   32'(bus.pending),   32'(e_pend));
    chk("mem_ready", 32'(bus.mem_ready), 32'(e_mrdy));
    chk("alu_ready", 32'(bus.alu_ready), 32'(e_ardy));
    chk("fwd_hit1",  32'(bus.fwd_hit1),  32'(e_h1));
    chk("fwd_data1", 32'(bus.fwd_data1), 32'(e_d1));
    chk("fwd_hit2",  32'(bus.fwd_hit2),  32'(e_h2));
    chk("fwd_data2", 32'(bus.fwd_data2), 32'(e_d2));
    m_acc = bus.mem_valid && e_mrdy;
    a_acc = bus.alu_valid && e_ardy;
    @(posedge clk);
    if (sz > 0) e = mq.pop_front();
    if (m_acc) begin e.r = bus.mem_reg; e.d = bus.mem_data; mq.push_back(e); end
    if (a_acc) begin e.r = bus.alu_reg; e.d = bus.alu_data; mq.push_back(e); end
    #1;
  endtask

  initial begin
    int mi;
    int ai;
    int guard;
    pass_cnt  = 0;
    total_cnt = 0;
    m_acc = 1'b0;
    a_acc = 1'b0;
    rst   = 1'b0;
    drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
    bus.fwd_reg1 = 4'd0;
    bus.fwd_reg2 = 4'd0;

    // Reset held: idle outputs.
    #2;
    chk("rst_write_en",  32'(bus.WriteReg),  32'd0);
    chk("rst_pending",   32'(bus.pending),   32'd0);
    chk("rst_mem_ready", 32'(bus.mem_ready), 32'd1);
    chk("rst_alu_ready", 32'(bus.alu_ready), 32'd1);
    chk("rst_fwd_hit1",  32'(bus.fwd_hit1),  32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    step();

    // Single ALU write.
    drive(1'b0, 4'd0, 16'd0, 1'b1, 4'd3, 16'h1234);
    step();
    drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
    #1;
    chk("single_we",      32'(bus.WriteReg), 32'd1);
    chk("single_dst",     32'(bus.DstReg),   32'd3);
    chk("single_data",    32'(bus.DstData),  32'h1234);
    chk("single_pending", 32'(bus.pending),  32'h0008);
    step();
    chk("single_done_we", 32'(bus.WriteReg), 32'd0);
    chk("single_done_pend", 32'(bus.pending), 32'd0);

    // Same-cycle pair to one register; alu is younger.
    drive(1'b1, 4'd5, 16'hAAAA, 1'b1, 4'd5, 16'hBBBB);
    step();
    drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
    bus.fwd_reg1 = 4'd5;
    #1;
    chk("pair_fwd_hit",  32'(bus.fwd_hit1),  32'd1);
    chk("pair_fwd_data", 32'(bus.fwd_data1), 32'hBBBB);
    chk("pair_first",    32'(bus.DstData),   32'hAAAA);
    step();
    chk("pair_second",   32'(bus.DstData),   32'hBBBB);
    chk("pair_pend5",    32'(bus.pending[5]), 32'd1);
    step();
    chk("pair_clear",    32'(bus.pending),   32'd0);

    // Fill with both producers every cycle; alu must stall once the queue is full.
    mi = 0;
    ai = 0;
    for (int cyc = 0; cyc < 40 && (mi < 5 || ai < 5); cyc++) begin
      drive(mi < 5, 4'(2 * mi), 16'hA000 + 16'(mi), ai < 5, 4'(2 * ai + 1), 16'hB000 + 16'(ai));
      if (cyc == 3) begin
        #1;
        chk("full_count",     32'(mq.size()),     32'(DEPTH));
        chk("full_mem_ready", 32'(bus.mem_ready), 32'd1);
        chk("full_alu_ready", 32'(bus.alu_ready), 32'd0);
      end
      step();
      if (m_acc) mi++;
      if (a_acc) ai++;
    end
    chk("fill_all_accepted", 32'(mi + ai), 32'd10);
    drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
    guard = 0;
    while (mq.size() > 0 && guard < 20) begin
      step();
      guard++;
    end
    chk("fill_drained", 32'(mq.size()), 32'd0);

    // Wrap: ten back-to-back ALU results.
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 4'd0, 16'd0, 1'b1, 4'(i), 16'h0100 + 16'(i));
      step();
      chk("wrap_dst",  32'(bus.DstReg),  32'(i));
      chk("wrap_data", 32'(bus.DstData), 32'h0100 + 32'(i));
    end
    drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
    step();
    step();

    // Reset with three entries queued.
    drive(1'b1, 4'd7, 16'h7777, 1'b1, 4'd8, 16'h8888);
    step();
    drive(1'b1, 4'd9, 16'h9999, 1'b1, 4'd10, 16'hAAAA);
    step();
    drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
    chk("mid_queued", 32'(mq.size()), 32'd3);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_we",      32'(bus.WriteReg),  32'd0);
    chk("mid_rst_pending", 32'(bus.pending),   32'd0);
    chk("mid_rst_ready",   32'(bus.alu_ready), 32'd1);
    mq.delete();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) step();

    // Random traffic; producers hold each offer until accepted.
    m_acc = 1'b0;
    a_acc = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!bus.mem_valid || m_acc) begin
        bus.mem_valid = ($urandom_range(0, 2) != 0);
        bus.mem_reg   = 4'($urandom);
        bus.mem_data  = 16'($urandom);
      end
      if (!bus.alu_valid || a_acc) begin
        bus.alu_valid = ($urandom_range(0, 2) != 0);
        bus.alu_reg   = 4'($urandom);
        bus.alu_data  = 16'($urandom);
      end
      bus.fwd_reg1 = 4'($urandom);
      bus.fwd_reg2 = 4'($urandom);
      step();
    end
    drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
    for (int i = 0; i < 6; i++) step();
    chk("final_empty", 32'(bus.WriteReg), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
